// File: rtl/mul_arb_pkg.sv
// Shared types and defaults for the two-requester multiplier arbiter.
// Imported by the arbiter top and its round-robin selector.
package mul_arb_pkg;

  localparam int unsigned DEF_TIMEOUT = 100;
  localparam int unsigned DEF_W       = 64;
  localparam int unsigned NUM_REQ     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    RSP  = 2'd3
  } state_e;

  // Requester index to its one-hot response/grant lane.
  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: on a tie the requester not granted last wins.
// Purely combinational; the caller owns the last-grant pointer.
module rr_arbiter2
  import mul_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one Booth multiplier between two requesters with round-robin grant,
// a clear-then-run sequence per operation, and a RUN-phase timeout.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned W       = DEF_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [W-1:0]         req_a0,
  input  logic [W-1:0]         req_b0,
  input  logic [W-1:0]         req_a1,
  input  logic [W-1:0]         req_b1,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [2*W-1:0]       resp_result,
  output logic                 resp_err,
  output logic                 mul_op_start,
  output logic                 mul_op_clear,
  output logic [W-1:0]         mul_multiplier,
  output logic [W-1:0]         mul_multiplicand,
  input  logic                 mul_op_done,
  input  logic [2*W-1:0]       mul_result
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                state_q;
  logic                  last_q;
  logic                  id_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_REQ-1:0]    resp_valid_q;
  logic [2*W-1:0]        resp_result_q;
  logic                  resp_err_q;
  logic                  start_q;
  logic                  clear_q;
  logic [W-1:0]          mplier_q;
  logic [W-1:0]          mcand_q;

  logic [NUM_REQ-1:0]    grant;
  logic                  hs;
  logic                  hs_id;
  logic                  run_exit;

  rr_arbiter2 u_rr (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  // Acceptance is the only combinational output; it exists only in IDLE.
  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign hs        = |(req_valid & req_ready);
  assign hs_id     = req_ready[1];
  assign run_exit  = mul_op_done || (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      id_q          <= 1'b0;
      cnt_q         <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
      start_q       <= 1'b0;
      clear_q       <= 1'b1;
      mplier_q      <= '0;
      mcand_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          clear_q <= 1'b0;
          if (hs) begin
            id_q     <= hs_id;
            last_q   <= hs_id;
            mplier_q <= hs_id ? req_a1 : req_a0;
            mcand_q  <= hs_id ? req_b1 : req_b0;
            clear_q  <= 1'b1;
            start_q  <= 1'b0;
            state_q  <= CLR;
          end
        end
        CLR: begin
          clear_q <= 1'b0;
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          // Done takes priority over a coincident timeout.
          if (run_exit) begin
            resp_result_q <= mul_op_done ? mul_result : '0;
            resp_err_q    <= !mul_op_done;
            resp_valid_q  <= id_to_onehot(id_q);
            start_q       <= 1'b0;
            clear_q       <= 1'b1;
            state_q       <= RSP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RSP: begin
          if (resp_ready[id_q]) begin
            resp_valid_q <= '0;
            clear_q      <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid       = resp_valid_q;
  assign resp_result      = resp_result_q;
  assign resp_err         = resp_err_q;
  assign mul_op_start     = start_q;
  assign mul_op_clear     = clear_q;
  assign mul_multiplier   = mplier_q;
  assign mul_multiplicand = mcand_q;

endmodule
